// File: rtl/hatch_imem.sv
// rtl/hatch_imem.sv - instruction store behind the CPU hatch fetch port with byte-serial loader
module hatch_imem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [31:0]           hatch_address,
    output logic [47:0]           hatch_instruction,
    output logic                  cpu_rst_b,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            byte_cnt;
    logic [39:0]           asm_word;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic                  overflow_q;
    logic                  byte_take;
    logic                  word_done;
    logic                  store_full;
    logic                  mem_we;
    logic                  addr_hit;
    logic                  rd_hit;
    logic [47:0]           rd_word;
    logic [47:0]           mem [DEPTH];

    // load_start restarts the load from any state, so it suppresses byte acceptance
    assign byte_take  = (state == ST_LOAD) && !load_start && load_valid;
    assign word_done  = byte_take && (byte_cnt == 3'd5);
    assign store_full = word_cnt[ADDR_WIDTH];
    assign mem_we     = word_done && !store_full;
    assign addr_hit   = (hatch_address[31:ADDR_WIDTH] == '0) &&
                        ({1'b0, hatch_address[ADDR_WIDTH-1:0]} < word_cnt);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_rst_b  = 1'b0;
        load_ready = 1'b0;
        case (state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_end) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_rst_b = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load_start) begin
            state_nxt = ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            byte_cnt   <= 3'd0;
            asm_word   <= '0;
            word_cnt   <= '0;
            overflow_q <= 1'b0;
            rd_hit     <= 1'b0;
        end else begin
            if (load_start) begin
                byte_cnt   <= 3'd0;
                word_cnt   <= '0;
                overflow_q <= 1'b0;
            end else if (state == ST_LOAD) begin
                if (byte_take) begin
                    byte_cnt <= (byte_cnt == 3'd5) ? 3'd0 : byte_cnt + 3'd1;
                    asm_word <= {asm_word[31:0], load_data};
                end
                if (word_done) begin
                    if (store_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                // a trailing partial word is thrown away when the load closes
                if (load_end) begin
                    byte_cnt <= 3'd0;
                end
            end
            rd_hit <= (state == ST_RUN) && !load_start && addr_hit;
        end
    end

    // single-port store: writes only happen in LOAD, reads only in RUN
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_cnt[ADDR_WIDTH-1:0]] <= {asm_word, load_data};
        end else if (state == ST_RUN) begin
            rd_word <= mem[hatch_address[ADDR_WIDTH-1:0]];
        end
    end

    assign hatch_instruction = ((state == ST_RUN) && rd_hit) ? rd_word : 48'h0;
    assign words_loaded      = word_cnt;
    assign load_overflow     = overflow_q;

endmodule

// File: tb/tb_hatch_imem.sv
// tb/tb_hatch_imem.sv - randomized self-checking bench for hatch_imem against a word-array model
module tb_hatch_imem;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] hatch_address;
    logic        load_start;
    logic        load_end;
    logic        load_valid;
    logic [7:0]  load_data;

    logic [47:0] instr_l, instr_s;
    logic        cpu_rst_b_l, cpu_rst_b_s;
    logic        ready_l, ready_s;
    logic [10:0] words_l;
    logic [2:0]  words_s;
    logic        ovf_l, ovf_s;

    int checks = 0;
    int errors = 0;

    logic [47:0] ref_l [1024];
    logic [47:0] ref_s [4];
    int          wl_l, wl_s;
    bit          ov_l, ov_s;
    logic [7:0]  bq [$];

    always #5 clk = ~clk;

    hatch_imem #(.ADDR_WIDTH(10)) u_dut (
        .clk(clk), .rst_b(rst_b), .hatch_address(hatch_address),
        .hatch_instruction(instr_l), .cpu_rst_b(cpu_rst_b_l),
        .load_start(load_start), .load_end(load_end), .load_valid(load_valid),
        .load_data(load_data), .load_ready(ready_l), .words_loaded(words_l),
        .load_overflow(ovf_l)
    );

    hatch_imem #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst_b(rst_b), .hatch_address(hatch_address),
        .hatch_instruction(instr_s), .cpu_rst_b(cpu_rst_b_s),
        .load_start(load_start), .load_end(load_end), .load_valid(load_valid),
        .load_data(load_data), .load_ready(ready_s), .words_loaded(words_s),
        .load_overflow(ovf_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] exp_l(input logic [31:0] a);
        if (a < 32'(wl_l)) return ref_l[a[9:0]];
        return 48'h0;
    endfunction

    function automatic logic [47:0] exp_s(input logic [31:0] a);
        if (a < 32'(wl_s)) return ref_s[a[1:0]];
        return 48'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cpurst_l"}, cpu_rst_b_l, cpu_rst_b_l === 1'bx ? 1'b0 : 1'b1);
    endtask

    task automatic fetch(input logic [31:0] a);
        hatch_address = a;
        step();
        check("fetch_l", instr_l, exp_l(a));
        check("fetch_s", instr_s, exp_s(a));
    endtask

    task automatic do_load(input int nbytes, input bit gapped, input bit end_with_byte, input bit seq);
        int full;
        logic [47:0] w;
        bq.delete();
        for (int i = 0; i < nbytes; i++) bq.push_back(seq ? 8'(i + 1) : 8'($urandom));
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wl_l = 0; wl_s = 0; ov_l = 0; ov_s = 0;
        check("start_ready", ready_l, 1'b1);
        check("start_cpurst", cpu_rst_b_l, 1'b0);
        check("start_words_l", words_l, 0);
        check("start_words_s", words_s, 0);
        check("start_ovf", ovf_s, 1'b0);
        check("start_instr", instr_l, 48'h0);
        for (int i = 0; i < nbytes; i++) begin
            if (gapped) begin
                repeat ($urandom_range(0, 2)) begin
                    load_valid = 1'b0;
                    load_data  = 8'($urandom);
                    step();
                end
            end
            load_valid = 1'b1;
            load_data  = bq[i];
            if (end_with_byte && i == nbytes - 1) load_end = 1'b1;
            step();
        end
        load_valid = 1'b0;
        if (!(end_with_byte && nbytes > 0)) begin
            load_end = 1'b1;
            step();
        end
        load_end = 1'b0;
        full = nbytes / 6;
        for (int j = 0; j < full; j++) begin
            w = {bq[6*j], bq[6*j+1], bq[6*j+2], bq[6*j+3], bq[6*j+4], bq[6*j+5]};
            if (j < 1024) ref_l[j] = w;
            if (j < 4) ref_s[j] = w;
        end
        wl_l = (full > 1024) ? 1024 : full;
        wl_s = (full > 4) ? 4 : full;
        ov_l = full > 1024;
        ov_s = full > 4;
        check("end_cpurst_l", cpu_rst_b_l, 1'b1);
        check("end_cpurst_s", cpu_rst_b_s, 1'b1);
        check("end_ready", ready_l, 1'b0);
        check("end_words_l", words_l, 64'(wl_l));
        check("end_words_s", words_s, 64'(wl_s));
        check("end_ovf_l", ovf_l, 64'(ov_l));
        check("end_ovf_s", ovf_s, 64'(ov_s));
    endtask

    initial begin
        rst_b = 1'b0;
        hatch_address = 32'h0;
        load_start = 1'b0;
        load_end   = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h0;
        wl_l = 0; wl_s = 0; ov_l = 0; ov_s = 0;
        #12;
        check("rst_instr", instr_l, 48'h0);
        check("rst_cpurst", cpu_rst_b_l, 1'b0);
        check("rst_ready", ready_l, 1'b0);
        check("rst_words", words_l, 0);
        check("rst_ovf", ovf_l, 1'b0);
        rst_b = 1'b1;
        step();
        check("idle_ready", ready_l, 1'b0);

        do_load(12, 1'b0, 1'b0, 1'b1);
        fetch(32'h0);
        check("basic_w0", instr_l, 48'h010203040506);
        fetch(32'h1);
        check("basic_w1", instr_l, 48'h0708090A0B0C);

        do_load(8, 1'b0, 1'b0, 1'b1);
        fetch(32'h1);
        fetch(32'h0000_0400);
        fetch(32'h0);

        do_load(30, 1'b0, 1'b0, 1'b0);
        check("ovf_small_set", ovf_s, 1'b1);
        for (int a = 0; a < 6; a++) fetch(32'(a));
        fetch(32'h3);
        fetch(32'h4);

        do_load(6, 1'b1, 1'b0, 1'b0);
        fetch(32'h0);
        fetch(32'h1);

        load_start = 1'b1;
        load_end   = 1'b1;
        step();
        load_start = 1'b0;
        load_end   = 1'b0;
        check("start_wins_ready", ready_l, 1'b1);
        check("start_wins_cpurst", cpu_rst_b_l, 1'b0);
        check("start_wins_words", words_l, 0);

        do_load(6, 1'b0, 1'b1, 1'b0);
        do_load(6, 1'b0, 1'b1, 1'b0);
        fetch(32'h0);

        for (int it = 0; it < 10; it++) begin
            do_load(int'($urandom_range(0, 45)), 1'($urandom), 1'($urandom), 1'b0);
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 3))
                    0: fetch($urandom);
                    1: fetch(32'h0000_0400 | 32'($urandom_range(0, 3)));
                    default: fetch(32'($urandom_range(0, 9)));
                endcase
            end
        end

        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            step();
        end
        load_valid = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        wl_l = 0; wl_s = 0; ov_l = 0; ov_s = 0;
        check("arst_instr", instr_l, 48'h0);
        check("arst_cpurst", cpu_rst_b_l, 1'b0);
        check("arst_ready_l", ready_l, 1'b0);
        check("arst_ready_s", ready_s, 1'b0);
        check("arst_words", words_l, 0);
        check("arst_ovf", ovf_l, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        fetch(32'h0);
        check("post_arst_ready", ready_l, 1'b0);
        check("post_arst_cpurst", cpu_rst_b_l, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
